// File: rtl/core_pkg.sv
// Shared types and constants for the PC-FX media/loader front-end.
package core_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_NEXT = 2'd3
    } bk_state_e;

    localparam logic VD_SRAM      = 1'b0;
    localparam logic VD_BMP       = 1'b1;
    localparam int   SECTOR_WORDS = 256;

    function automatic logic [1:0] disk_onehot(input logic disk);
        return disk ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/pcfx_ioctl_rom_wr.sv
// ioctl download -> SDRAM write handshake; one word in flight, host stalled until acked.
module pcfx_ioctl_rom_wr #(
    parameter logic [24:0] ROM_BASE_A = 25'h000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        download_i,
    input  logic [7:0]  index_i,
    input  logic        wr_i,
    input  logic [24:0] addr_i,
    input  logic [15:0] dout_i,
    input  logic        ack_i,
    output logic        req_o,
    output logic [24:0] addr_o,
    output logic [15:0] wdata_o,
    output logic        wait_o
);

    logic        busy_q, busy_d;
    logic [24:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            busy_q <= busy_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    always_comb begin
        busy_d = busy_q;
        addr_d = addr_q;
        data_d = data_q;
        if (!busy_q && download_i && (index_i == 8'd0) && wr_i) begin
            busy_d = 1'b1;
            addr_d = ROM_BASE_A + addr_i;
            data_d = dout_i;
        end else if (busy_q && ack_i) begin
            busy_d = 1'b0;
        end
    end

    // The SDRAM request and the host stall are the same condition.
    assign req_o   = busy_q;
    assign wait_o  = busy_q;
    assign addr_o  = addr_q;
    assign wdata_o = data_q;

endmodule

// File: rtl/pcfx_media_if.sv
// PC-FX media front-end: BIOS download into SDRAM and backup RAM load/save over virtual SD disks.
module pcfx_media_if
    import core_pkg::*;
#(
    parameter logic [24:0] ROM_BASE_A   = 25'h000_0000,
    parameter int          SRAM_SECTORS = 64,
    parameter int          BMP_SECTORS  = 256
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [1:0]  img_mounted,
    input  logic        img_readonly,
    input  logic [63:0] img_size,
    output logic [31:0] sd_lba,
    output logic [1:0]  sd_rd,
    output logic [1:0]  sd_wr,
    input  logic [1:0]  sd_ack,
    input  logic [7:0]  sd_buff_addr,
    input  logic [15:0] sd_buff_dout,
    input  logic        sd_buff_wr,
    output logic [15:0] sd_buff_din,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [15:0] ioctl_dout,
    output logic        ioctl_wait,
    output logic        bk_ena,
    input  logic        bk_load,
    input  logic        bk_save,
    output logic        bk_loading,
    output logic        rom_req,
    output logic [24:0] rom_addr,
    output logic [15:0] rom_wdata,
    input  logic        rom_ack,
    output logic [15:0] bk_addr,
    output logic        bk_we,
    output logic [15:0] bk_wdata,
    input  logic [15:0] bk_rdata
);

    localparam logic [15:0] BMP_BASE  = 16'(SRAM_SECTORS * SECTOR_WORDS);
    localparam logic [7:0]  SRAM_LAST = 8'(SRAM_SECTORS - 1);
    localparam logic [7:0]  BMP_LAST  = 8'(BMP_SECTORS - 1);

    bk_state_e   state_q, state_d;
    logic        disk_q, disk_d;
    logic [7:0]  sector_q, sector_d;
    logic        save_q, save_d;
    logic [1:0]  sd_rd_q, sd_rd_d;
    logic [1:0]  sd_wr_q, sd_wr_d;
    logic [1:0]  mounted_q, ro_q;
    logic        load_prev_q, save_prev_q;

    logic        load_rise, save_rise;
    logic [1:0]  save_ok, eligible;
    logic [7:0]  last_sector;
    logic        xfer;
    logic [15:0] word_addr;

    pcfx_ioctl_rom_wr #(.ROM_BASE_A(ROM_BASE_A)) u_rom_wr (
        .clk_i      (clk_sys),
        .rst_ni     (reset_n),
        .download_i (ioctl_download),
        .index_i    (ioctl_index),
        .wr_i       (ioctl_wr),
        .addr_i     (ioctl_addr),
        .dout_i     (ioctl_dout),
        .ack_i      (rom_ack),
        .req_o      (rom_req),
        .addr_o     (rom_addr),
        .wdata_o    (rom_wdata),
        .wait_o     (ioctl_wait)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            mounted_q   <= 2'b00;
            ro_q        <= 2'b00;
            load_prev_q <= 1'b0;
            save_prev_q <= 1'b0;
        end else begin
            load_prev_q <= bk_load;
            save_prev_q <= bk_save;
            for (int v = 0; v < 2; v++) begin
                if (img_mounted[v]) begin
                    mounted_q[v] <= (img_size != 64'd0);
                    ro_q[v]      <= img_readonly;
                end
            end
        end
    end

    assign load_rise   = bk_load & ~load_prev_q;
    assign save_rise   = bk_save & ~save_prev_q;
    assign save_ok     = mounted_q & ~ro_q;
    assign eligible    = save_q ? save_ok : mounted_q;
    assign last_sector = (disk_q == VD_BMP) ? BMP_LAST : SRAM_LAST;

    // State register (plus the request strobes, which lag state entry by one cycle).
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            disk_q   <= VD_SRAM;
            sector_q <= 8'd0;
            save_q   <= 1'b0;
            sd_rd_q  <= 2'b00;
            sd_wr_q  <= 2'b00;
        end else begin
            state_q  <= state_d;
            disk_q   <= disk_d;
            sector_q <= sector_d;
            save_q   <= save_d;
            sd_rd_q  <= sd_rd_d;
            sd_wr_q  <= sd_wr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        disk_d   = disk_q;
        sector_d = sector_q;
        save_d   = save_q;
        case (state_q)
            ST_IDLE: begin
                if (load_rise && bk_ena) begin
                    state_d  = ST_REQ;
                    save_d   = 1'b0;
                    disk_d   = mounted_q[0] ? VD_SRAM : VD_BMP;
                    sector_d = 8'd0;
                end else if (save_rise && (save_ok != 2'b00)) begin
                    state_d  = ST_REQ;
                    save_d   = 1'b1;
                    disk_d   = save_ok[0] ? VD_SRAM : VD_BMP;
                    sector_d = 8'd0;
                end
            end
            ST_REQ:  if (sd_ack[disk_q])  state_d = ST_XFER;
            ST_XFER: if (!sd_ack[disk_q]) state_d = ST_NEXT;
            ST_NEXT: begin
                if (sector_q != last_sector) begin
                    sector_d = sector_q + 8'd1;
                    state_d  = ST_REQ;
                end else if ((disk_q == VD_SRAM) && eligible[1]) begin
                    disk_d   = VD_BMP;
                    sector_d = 8'd0;
                    state_d  = ST_REQ;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sd_rd_d = 2'b00;
        sd_wr_d = 2'b00;
        if ((state_q == ST_REQ) && !sd_ack[disk_q]) begin
            if (save_q) sd_wr_d = disk_onehot(disk_q);
            else        sd_rd_d = disk_onehot(disk_q);
        end
        xfer = (state_q == ST_XFER);
        // BMP words past 64K wrap onto the start of the BRAM word space.
        word_addr   = ((disk_q == VD_BMP) ? BMP_BASE : 16'd0) + {sector_q, 8'h00}
                      + {8'h00, sd_buff_addr};
        bk_addr     = xfer ? word_addr : 16'd0;
        bk_we       = xfer && !save_q && sd_buff_wr;
        bk_wdata    = (xfer && !save_q) ? sd_buff_dout : 16'd0;
        sd_buff_din = (xfer && save_q) ? bk_rdata : 16'd0;
        bk_loading  = (state_q != ST_IDLE) && !save_q;
        bk_ena      = |mounted_q;
        sd_lba      = {24'd0, sector_q};
        sd_rd       = sd_rd_q;
        sd_wr       = sd_wr_q;
    end

endmodule

// File: tb/tb_pcfx_media_if.sv
// Directed bench for pcfx_media_if: host disk model, BRAM model, ioctl download.
module tb_pcfx_media_if;

    localparam logic [24:0] ROM_BASE = 25'h010_0000;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  img_mounted = 2'b00;
    logic        img_readonly = 1'b0;
    logic [63:0] img_size = 64'd0;
    logic [31:0] sd_lba;
    logic [1:0]  sd_rd, sd_wr;
    logic [1:0]  sd_ack = 2'b00;
    logic [7:0]  sd_buff_addr = 8'd0;
    logic [15:0] sd_buff_dout = 16'd0;
    logic        sd_buff_wr = 1'b0;
    logic [15:0] sd_buff_din;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = 25'd0;
    logic [15:0] ioctl_dout = 16'd0;
    logic        ioctl_wait;
    logic        bk_ena;
    logic        bk_load = 1'b0;
    logic        bk_save = 1'b0;
    logic        bk_loading;
    logic        rom_req;
    logic [24:0] rom_addr;
    logic [15:0] rom_wdata;
    logic        rom_ack = 1'b0;
    logic [15:0] bk_addr;
    logic        bk_we;
    logic [15:0] bk_wdata;
    logic [15:0] bk_rdata = 16'd0;

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] mem [0:65535];
    logic [7:0]  wl [3] = '{8'd0, 8'd5, 8'd255};

    pcfx_media_if #(
        .ROM_BASE_A   (ROM_BASE),
        .SRAM_SECTORS (64),
        .BMP_SECTORS  (256)
    ) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .img_mounted    (img_mounted),
        .img_readonly   (img_readonly),
        .img_size       (img_size),
        .sd_lba         (sd_lba),
        .sd_rd          (sd_rd),
        .sd_wr          (sd_wr),
        .sd_ack         (sd_ack),
        .sd_buff_addr   (sd_buff_addr),
        .sd_buff_dout   (sd_buff_dout),
        .sd_buff_wr     (sd_buff_wr),
        .sd_buff_din    (sd_buff_din),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .bk_ena         (bk_ena),
        .bk_load        (bk_load),
        .bk_save        (bk_save),
        .bk_loading     (bk_loading),
        .rom_req        (rom_req),
        .rom_addr       (rom_addr),
        .rom_wdata      (rom_wdata),
        .rom_ack        (rom_ack),
        .bk_addr        (bk_addr),
        .bk_we          (bk_we),
        .bk_wdata       (bk_wdata),
        .bk_rdata       (bk_rdata)
    );

    // Clock / reset block
    always #5 clk_sys = ~clk_sys;

    // Backup BRAM model, one cycle read latency
    always @(posedge clk_sys) begin
        if (bk_we) mem[bk_addr] <= bk_wdata;
        bk_rdata <= mem[bk_addr];
    end

    function automatic logic [15:0] pat(input int d, input int s, input int w);
        return {4'(d), 8'(s), 4'(w)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mount(input logic [1:0] v, input logic [63:0] size, input logic ro);
        @(negedge clk_sys);
        img_mounted  = v;
        img_size     = size;
        img_readonly = ro;
        @(negedge clk_sys);
        img_mounted  = 2'b00;
        @(negedge clk_sys);
    endtask

    task automatic ioctl_word(input logic [7:0] idx, input logic [24:0] a, input logic [15:0] d);
        @(negedge clk_sys);
        ioctl_download = 1'b1;
        ioctl_index    = idx;
        ioctl_addr     = a;
        ioctl_dout     = d;
        ioctl_wr       = 1'b1;
        @(posedge clk_sys); #1;
        ioctl_wr       = 1'b0;
    endtask

    task automatic wait_req(input bit save, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_sys);
            if ((save ? sd_wr : sd_rd) != 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Host side of one sector: see the request, ack it, move nw words, drop ack.
    task automatic serve(input bit save, input int disk, input int lba, input int nw);
        bit ok;
        logic [1:0] oh;
        oh = (disk == 1) ? 2'b10 : 2'b01;
        wait_req(save, ok);
        check("req_seen", 32'(ok), 32'd1);
        if (!ok) return;
        check("req_vec", 32'(save ? sd_wr : sd_rd), 32'(oh));
        check("sd_lba", sd_lba, 32'(lba));
        @(posedge clk_sys); #1;
        sd_ack = oh;
        @(posedge clk_sys);
        @(negedge clk_sys);
        check("req_drop", 32'(save ? sd_wr : sd_rd), 32'd0);
        for (int w = 0; w < nw; w++) begin
            sd_buff_addr = wl[w];
            if (!save) begin
                sd_buff_dout = pat(disk, lba, int'(wl[w]));
                sd_buff_wr   = 1'b1;
                @(posedge clk_sys); #1;
                sd_buff_wr   = 1'b0;
                @(posedge clk_sys); #1;
            end else begin
                @(posedge clk_sys);
                @(negedge clk_sys);
                check("sd_buff_din", 32'(sd_buff_din), 32'(pat(0, lba, int'(wl[w]))));
                check("save_no_we", 32'(bk_we), 32'd0);
            end
        end
        sd_ack = 2'b00;
        @(posedge clk_sys); #1;
    endtask

    initial begin
        bit seen;
        bit ok;
        for (int i = 0; i < 65536; i++) mem[i] = 16'd0;

        // Reset state
        repeat (3) @(negedge clk_sys);
        check("rst_sd_rd", 32'(sd_rd), 32'd0);
        check("rst_sd_wr", 32'(sd_wr), 32'd0);
        check("rst_rom_req", 32'(rom_req), 32'd0);
        check("rst_ioctl_wait", 32'(ioctl_wait), 32'd0);
        check("rst_bk_ena", 32'(bk_ena), 32'd0);
        check("rst_bk_loading", 32'(bk_loading), 32'd0);
        check("rst_bk_we", 32'(bk_we), 32'd0);
        check("rst_sd_lba", sd_lba, 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_sys);

        // ROM download, index 0
        ioctl_word(8'd0, 25'd0, 16'h1234);
        check("rom1_wait", 32'(ioctl_wait), 32'd1);
        check("rom1_req", 32'(rom_req), 32'd1);
        check("rom1_addr", 32'(rom_addr), 32'h0010_0000);
        check("rom1_data", 32'(rom_wdata), 32'h1234);
        repeat (2) @(posedge clk_sys);
        #1 check("rom1_wait_hold", 32'(ioctl_wait), 32'd1);
        rom_ack = 1'b1;
        @(posedge clk_sys); #1;
        rom_ack = 1'b0;
        check("rom1_wait_drop", 32'(ioctl_wait), 32'd0);
        check("rom1_req_drop", 32'(rom_req), 32'd0);
        ioctl_word(8'd0, 25'd2, 16'hABCD);
        check("rom2_addr", 32'(rom_addr), 32'h0010_0002);
        check("rom2_data", 32'(rom_wdata), 32'hABCD);
        rom_ack = 1'b1;
        @(posedge clk_sys); #1;
        rom_ack = 1'b0;
        check("rom2_wait_drop", 32'(ioctl_wait), 32'd0);
        ioctl_word(8'd1, 25'd4, 16'h5555);
        check("rom_idx1_wait", 32'(ioctl_wait), 32'd0);
        check("rom_idx1_req", 32'(rom_req), 32'd0);
        ioctl_download = 1'b0;

        // Load with nothing mounted is ignored
        @(negedge clk_sys);
        bk_load = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_sys);
            if (sd_rd != 2'b00 || bk_loading) seen = 1'b1;
        end
        check("load_unmounted", 32'(seen), 32'd0);
        bk_load = 1'b0;

        // Mounting
        mount(2'b10, 64'd0, 1'b0);
        check("mount_size0", 32'(bk_ena), 32'd0);
        mount(2'b01, 64'd32768, 1'b0);
        check("mount_sram", 32'(bk_ena), 32'd1);
        mount(2'b10, 64'd131072, 1'b0);

        // Load both disks
        bk_load = 1'b1;
        for (int s = 0; s < 64; s++) begin
            serve(1'b0, 0, s, 3);
            if (s == 0) begin
                bk_load = 1'b0;
                check("loading_mid", 32'(bk_loading), 32'd1);
            end
        end
        for (int s = 0; s < 256; s++) serve(1'b0, 1, s, (s < 4) ? 3 : 0);
        @(posedge clk_sys);
        @(posedge clk_sys);
        @(negedge clk_sys);
        check("loading_done", 32'(bk_loading), 32'd0);
        check("bram_d1_s2_w5", 32'(mem[16901]), 32'h1025);
        check("bram_d0_s3_w5", 32'(mem[773]), 32'h0035);
        check("bram_d1_s0_w255", 32'(mem[16639]), 32'h100F);

        // Save with disk 1 read-only: only disk 0 is written back
        mount(2'b10, 64'd131072, 1'b1);
        bk_save = 1'b1;
        for (int s = 0; s < 64; s++) begin
            serve(1'b1, 0, s, 3);
            if (s == 0) begin
                bk_save = 1'b0;
                check("save_not_loading", 32'(bk_loading), 32'd0);
            end
        end
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_sys);
            if (sd_wr != 2'b00 || sd_rd != 2'b00) seen = 1'b1;
        end
        check("save_skip_ro", 32'(seen), 32'd0);

        // Reset during sector 10 of a load
        @(negedge clk_sys);
        bk_load = 1'b1;
        for (int s = 0; s < 10; s++) begin
            serve(1'b0, 0, s, 0);
            bk_load = 1'b0;
        end
        ioctl_word(8'd0, 25'd8, 16'h0F0F);
        check("pre_rst_rom_req", 32'(rom_req), 32'd1);
        wait_req(1'b0, ok);
        check("s10_req_seen", 32'(ok), 32'd1);
        check("s10_lba", sd_lba, 32'd10);
        @(posedge clk_sys); #1;
        sd_ack = 2'b01;
        @(posedge clk_sys);
        @(negedge clk_sys);
        sd_buff_addr = 8'd7;
        sd_buff_dout = 16'hBEEF;
        sd_buff_wr   = 1'b1;
        #1 check("pre_rst_bk_we", 32'(bk_we), 32'd1);
        reset_n = 1'b0;
        @(posedge clk_sys); #1;
        check("rst_mid_bk_we", 32'(bk_we), 32'd0);
        check("rst_mid_sd_rd", 32'(sd_rd), 32'd0);
        check("rst_mid_sd_wr", 32'(sd_wr), 32'd0);
        check("rst_mid_rom_req", 32'(rom_req), 32'd0);
        check("rst_mid_loading", 32'(bk_loading), 32'd0);
        check("rst_mid_bk_ena", 32'(bk_ena), 32'd0);
        sd_buff_wr     = 1'b0;
        sd_ack         = 2'b00;
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);
        check("post_rst_sd_rd", 32'(sd_rd), 32'd0);
        mount(2'b01, 64'd32768, 1'b0);
        bk_load = 1'b1;
        for (int s = 0; s < 64; s++) begin
            serve(1'b0, 0, s, 0);
            bk_load = 1'b0;
        end
        @(posedge clk_sys);
        @(posedge clk_sys);
        @(negedge clk_sys);
        check("reload_done", 32'(bk_loading), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
